// File: rtl/lcd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : lcd_ctrl                                                      |
// | Function : HD44780-style character LCD write controller, 8- or 4-bit bus |
// |            with an optional power-on init sequence (macro LCD_INIT_EN).  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module lcd_ctrl #(
  parameter int BUS_W     = 8,
  parameter int SETUP_CYC = 5,
  parameter int E_CYC     = 50,
  parameter int CMD_CYC   = 4000,
  parameter int CLR_CYC   = 160000,
  parameter int PWR_CYC   = 1500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic             cmd_rs,
  input  logic [7:0]       cmd_data,
  output logic             cmd_ready,
  output logic             init_done,
  output logic             lcd_rs,
  output logic             lcd_e,
  output logic [BUS_W-1:0] lcd_data
);

  localparam logic [2:0] c_ST_PWR   = 3'd0;
  localparam logic [2:0] c_ST_IDLE  = 3'd1;
  localparam logic [2:0] c_ST_SETUP = 3'd2;
  localparam logic [2:0] c_ST_EHIGH = 3'd3;
  localparam logic [2:0] c_ST_ELOW  = 3'd4;
  localparam logic [2:0] c_ST_WAIT  = 3'd5;

  localparam logic [23:0] c_SETUP_LAST = 24'(SETUP_CYC - 1);
  localparam logic [23:0] c_E_LAST     = 24'(E_CYC - 1);
  localparam logic [23:0] c_CMD_LAST   = 24'(CMD_CYC - 1);
  localparam logic [23:0] c_CLR_LAST   = 24'(CLR_CYC - 1);
  localparam logic [23:0] c_PWR_LAST   = 24'(PWR_CYC - 1);

`ifdef LCD_INIT_EN
  localparam logic [2:0] c_ST_RESET   = c_ST_PWR;
  localparam logic [3:0] c_INIT_STEPS = (BUS_W == 4) ? 4'd9 : 4'd8;
`else
  localparam logic [2:0] c_ST_RESET   = c_ST_IDLE;
  localparam logic [3:0] c_INIT_STEPS = 4'd0;
`endif

  logic [2:0]  r_state;
  logic [23:0] r_cnt;
  logic        r_rs;
  logic [7:0]  r_data;
  logic        r_nib;
  logic        r_single;
  logic        r_long;
  logic        r_init_done;
  logic [3:0]  r_init_idx;

  logic        w_active;
  logic [9:0]  w_init_step;

  // Init step encoding: {single_pulse, long_wait, byte}. The 8-bit bus has no 0x20 step.
  function automatic logic [9:0] init_step(input logic [3:0] idx);
    logic [3:0] k;
    k = (BUS_W == 8 && idx >= 4'd3) ? idx + 4'd1 : idx;
    case (k)
      4'd0, 4'd1, 4'd2: init_step = {1'b1, 1'b1, 8'h30};
      4'd3:             init_step = {1'b1, 1'b0, 8'h20};
      4'd4:             init_step = {1'b0, 1'b0, (BUS_W == 4) ? 8'h28 : 8'h38};
      4'd5:             init_step = {1'b0, 1'b0, 8'h08};
      4'd6:             init_step = {1'b0, 1'b1, 8'h01};
      4'd7:             init_step = {1'b0, 1'b0, 8'h06};
      default:          init_step = {1'b0, 1'b0, 8'h0C};
    endcase
  endfunction

  assign w_init_step = init_step(r_init_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_ST_RESET;
      r_cnt       <= '0;
      r_rs        <= 1'b0;
      r_data      <= '0;
      r_nib       <= 1'b0;
      r_single    <= 1'b0;
      r_long      <= 1'b0;
      r_init_done <= 1'b0;
      r_init_idx  <= '0;
    end else begin
      case (r_state)
        c_ST_PWR: begin
          if (r_cnt == c_PWR_LAST) begin
            r_cnt   <= '0;
            r_state <= c_ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 24'd1;
          end
        end
        c_ST_IDLE: begin
          r_cnt <= '0;
          r_nib <= 1'b0;
          if (!r_init_done) begin
            if (r_init_idx == c_INIT_STEPS) begin
              r_init_done <= 1'b1;
            end else begin
              r_rs                       <= 1'b0;
              {r_single, r_long, r_data} <= w_init_step;
              r_init_idx                 <= r_init_idx + 4'd1;
              r_state                    <= c_ST_SETUP;
            end
          end else if (cmd_valid) begin
            r_rs     <= cmd_rs;
            r_data   <= cmd_data;
            r_single <= 1'b0;
            // Clear display / return home need the long settle time
            r_long   <= !cmd_rs && (cmd_data[7:2] == 6'd0);
            r_state  <= c_ST_SETUP;
          end
        end
        c_ST_SETUP: begin
          if (r_cnt == c_SETUP_LAST) begin
            r_cnt   <= '0;
            r_state <= c_ST_EHIGH;
          end else begin
            r_cnt <= r_cnt + 24'd1;
          end
        end
        c_ST_EHIGH: begin
          if (r_cnt == c_E_LAST) begin
            r_cnt   <= '0;
            r_state <= c_ST_ELOW;
          end else begin
            r_cnt <= r_cnt + 24'd1;
          end
        end
        c_ST_ELOW: begin
          if (r_cnt == c_SETUP_LAST) begin
            r_cnt <= '0;
            if (BUS_W == 4 && !r_nib && !r_single) begin
              r_nib   <= 1'b1;
              r_state <= c_ST_SETUP;
            end else begin
              r_state <= c_ST_WAIT;
            end
          end else begin
            r_cnt <= r_cnt + 24'd1;
          end
        end
        c_ST_WAIT: begin
          if (r_cnt == (r_long ? c_CLR_LAST : c_CMD_LAST)) begin
            r_cnt   <= '0;
            r_state <= c_ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 24'd1;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decode straight from state so reset pulls lcd_e low without a clock
  assign w_active  = (r_state == c_ST_SETUP) || (r_state == c_ST_EHIGH) ||
                     (r_state == c_ST_ELOW);
  assign lcd_e     = (r_state == c_ST_EHIGH);
  assign lcd_rs    = w_active && r_rs;
  assign cmd_ready = (r_state == c_ST_IDLE) && r_init_done;
  assign init_done = r_init_done;

  generate
    if (BUS_W == 4) begin : g_bus4
      assign lcd_data = w_active ? (r_nib ? r_data[3:0] : r_data[7:4]) : 4'h0;
    end else begin : g_bus8
      assign lcd_data = w_active ? r_data : 8'h00;
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/lcd_ctrl.md
LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 SHALL have parameter BUS_W, default 8, LCD data bus width; legal values 8 or 4.
REQ-002 SHALL have parameter SETUP_CYC, default 5, clk cycles from rs/data valid to e rise (>=1).
REQ-003 SHALL have parameter E_CYC, default 50, clk cycles e held high (>=1).
REQ-004 SHALL have parameter CMD_CYC, default 4000, clk cycles of post-write wait for ordinary commands/characters (>=1).
REQ-005 SHALL have parameter CLR_CYC, default 160000, clk cycles of post-write wait for clear/home commands (>=1).
REQ-006 SHALL have parameter PWR_CYC, default 1500000, clk cycles of power-on wait (>=1); all delay counters 24 bits wide.
REQ-007 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port cmd_valid, input, 1, host request strobe.
REQ-010 SHALL have port cmd_rs, input, 1, 0 = instruction, 1 = character data.
REQ-011 SHALL have port cmd_data, input, 8, byte to write.
REQ-012 SHALL have port cmd_ready, output, 1, controller can accept a request.
REQ-013 SHALL have port init_done, output, 1, power-on sequence finished.
REQ-014 SHALL have port lcd_rs, output, 1, LCD register select.
REQ-015 SHALL have port lcd_e, output, 1, LCD enable strobe.
REQ-016 SHALL have port lcd_data, output, BUS_W, LCD data bus (BUS_W=4 drives DB7..DB4).

Function
REQ-017 SHALL accept a request on the clk edge where cmd_valid and cmd_ready are both 1; cmd_rs/cmd_data captured into internal registers at that edge.
REQ-018 SHALL deassert cmd_ready the cycle after acceptance until the post-write wait of that request ends; cmd_ready SHALL be 1 only in IDLE with init_done=1.
REQ-019 SHALL run states IDLE -> SETUP (SETUP_CYC) -> E_HIGH (E_CYC) -> E_LOW (SETUP_CYC) -> WAIT -> IDLE; each state lasts exactly its cycle count.
REQ-020 SHALL hold lcd_rs and lcd_data stable from SETUP entry through E_LOW exit; lcd_e=1 only in E_HIGH.
REQ-021 SHALL, for BUS_W=4, send high nibble then low nibble, each through SETUP/E_HIGH/E_LOW, with WAIT only after the low nibble.
REQ-022 SHALL use CLR_CYC for WAIT when cmd_rs=0 and cmd_data[7:2]=0 (0x00..0x03), otherwise CMD_CYC.
REQ-023 SHALL ignore cmd_valid while cmd_ready=0; no queuing, no loss of the request in flight.
REQ-024 SHALL drive lcd_rs=0, lcd_e=0, lcd_data=0 in IDLE.
REQ-025 SHALL accept a new request in the first cycle cmd_ready returns to 1 (back-to-back, no idle gap beyond that cycle).

Reset
REQ-026 SHALL on rst=1 immediately (asynchronously) force lcd_e=0, lcd_rs=0, lcd_data=0, cmd_ready=0, init_done=0, counters 0, state to power-on wait (or IDLE without LCD_INIT_EN).
REQ-027 SHALL abort any write in progress on reset, including mid E_HIGH; lcd_e SHALL fall in the same cycle rst rises.

Configuration
REQ-028 SHALL include the power-on init sequence only when macro LCD_INIT_EN is defined.
REQ-029 SHALL with LCD_INIT_EN: wait PWR_CYC, write 0x30 three times (CLR_CYC wait each); BUS_W=4 then write 0x20; all single high nibble only; then full writes 0x38 (BUS_W=8) or 0x28 (BUS_W=4), 0x08, 0x01, 0x06, 0x0C; assert init_done after the final WAIT.
REQ-030 SHALL without LCD_INIT_EN: assert init_done and cmd_ready in the first cycle after rst falls.

Verification (BUS_W=8, SETUP_CYC=2, E_CYC=4, CMD_CYC=10, CLR_CYC=50, PWR_CYC=100 unless stated)
REQ-031 SHALL cover: no LCD_INIT_EN, write rs=1 data=0x41 -> lcd_rs=1, lcd_data=0x41, lcd_e high 4 cycles after 2 setup, cmd_ready back 10 cycles after E_LOW ends.
REQ-032 SHALL cover: write rs=0 data=0x01 -> WAIT 50 cycles; rs=0 data=0x04 -> WAIT 10 cycles.
REQ-033 SHALL cover: BUS_W=4, write 0xA5 -> two e pulses with lcd_data 0xA then 0x5, single 10-cycle WAIT.
REQ-034 SHALL cover: LCD_INIT_EN, BUS_W=4 -> 100-cycle wait, nibbles 0x3,0x3,0x3,0x2, then bytes 0x28,0x08,0x01,0x06,0x0C, then init_done=1.
REQ-035 SHALL cover: rst asserted during E_HIGH -> lcd_e=0 same cycle; after release, next write completes normally.
REQ-036 SHALL cover: cmd_valid held high continuously with changing data -> only bytes present at ready cycles written, none duplicated.
